// File: rtl/vga_pkg.sv
// Timing defaults and shared types for the debug-screen VGA receive decoder.
package vga_pkg;

    localparam int   H_VIS_DEF       = 640;
    localparam int   H_FP_DEF        = 16;
    localparam int   H_SYNC_DEF      = 96;
    localparam int   H_BP_DEF        = 48;
    localparam int   H_TOT_DEF       = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int   V_VIS_DEF       = 480;
    localparam int   V_FP_DEF        = 10;
    localparam int   V_SYNC_DEF      = 2;
    localparam int   V_BP_DEF        = 33;
    localparam int   V_TOT_DEF       = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic SYNC_POL_DEF    = 1'b0;
    localparam int   LOCK_FRAMES_DEF = 2;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ALIGN    = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Strobe-qualified sample of one sync line plus a pulse on entry into the asserted level.
module vga_sync_edge #(
    parameter logic SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sync_in,
    output logic start
);

    logic sample_q;
    logic sample_d;

    always_comb begin
        sample_d = sample_q;
        if (en) begin
            sample_d = sync_in;
        end
    end

    // Idle level after reset, so a sync already asserted at release still counts as a start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= ~SYNC_POL;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign start = en && (sync_in == SYNC_POL) && (sample_q != SYNC_POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA decoder: recovers pixel coordinates, checks line/frame timing,
// tracks lock and captures the colour at a probe coordinate.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int   H_VIS       = H_VIS_DEF,
    parameter int   H_FP        = H_FP_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BP        = H_BP_DEF,
    parameter int   V_VIS       = V_VIS_DEF,
    parameter int   V_FP        = V_FP_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BP        = V_BP_DEF,
    parameter logic SYNC_POL    = SYNC_POL_DEF,
    parameter int   LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  R,
    input  logic [3:0]  G,
    input  logic [3:0]  B,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        probe_hit,
    output logic [11:0] probe_rgb,
    output logic        frame_done,
    output logic        locked,
    output logic        h_err,
    output logic        v_err
);

    localparam int          H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int          V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] HCNT_MAX  = 11'h7FF;
    localparam logic [10:0] H_LAST    = 11'(H_TOT - 1);
    localparam logic [10:0] H_TMO_PRE = 11'(2 * H_TOT - 1);
    localparam logic [10:0] H_START   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END     = 11'(H_SYNC + H_BP + H_VIS - 1);
    localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BP + V_VIS - 1);
    localparam logic [10:0] V_TOT_L   = 11'(V_TOT);
    localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);

    logic [1:0] sync_in;
    logic [1:0] sync_start;
    logic       hs_start;
    logic       vs_start;

    assign sync_in = {vsync, hsync};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_edge
        vga_sync_edge #(
            .SYNC_POL (SYNC_POL)
        ) u_edge (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .sync_in (sync_in[gi]),
            .start   (sync_start[gi])
        );
    end

    assign hs_start = sync_start[0];
    assign vs_start = sync_start[1];

    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        seen_h_q, seen_h_d;
    logic        seen_v_q, seen_v_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [11:0] pix_rgb_q, pix_rgb_d;
    logic        probe_hit_q, probe_hit_d;
    logic [11:0] probe_rgb_q, probe_rgb_d;
    logic        frame_done_q, frame_done_d;
    logic        h_err_q, h_err_d;
    logic        v_err_q, v_err_d;
    logic [10:0] line_cnt;
    lock_state_e state_q, state_d;
    logic [7:0]  good_q, good_d;

    always_comb begin
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        seen_h_d     = seen_h_q;
        seen_v_d     = seen_v_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_rgb_d    = pix_rgb_q;
        probe_hit_d  = 1'b0;
        probe_rgb_d  = probe_rgb_q;
        frame_done_d = 1'b0;
        h_err_d      = 1'b0;
        v_err_d      = 1'b0;
        // A start coincident with this vsync start belongs to the frame just ending.
        line_cnt     = {1'b0, vcnt_q} + {10'd0, hs_start};

        if (en) begin
            if (hs_start) begin
                hcnt_d   = 11'd0;
                seen_h_d = 1'b1;
                h_err_d  = seen_h_q && (hcnt_q != H_LAST);
            end else begin
                if (hcnt_q != HCNT_MAX) begin
                    hcnt_d = hcnt_q + 11'd1;
                end
                h_err_d = (hcnt_q == H_TMO_PRE);
            end

            if (vs_start) begin
                vcnt_d       = 10'd0;
                seen_v_d     = 1'b1;
                frame_done_d = 1'b1;
                v_err_d      = seen_v_q && (line_cnt != V_TOT_L);
            end else if (hs_start) begin
                vcnt_d = vcnt_q + 10'd1;
            end

            // Position of the pixel on this strobe is the updated counter value.
            if ((hcnt_d >= H_START) && (hcnt_d <= H_END) &&
                (vcnt_d >= V_START) && (vcnt_d <= V_END)) begin
                pix_valid_d = 1'b1;
                pix_x_d     = 10'(hcnt_d - H_START);
                pix_y_d     = vcnt_d - V_START;
                pix_rgb_d   = {R, G, B};
                if ((pix_x_d == probe_x) && (pix_y_d == probe_y)) begin
                    probe_hit_d = 1'b1;
                    probe_rgb_d = {R, G, B};
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            UNLOCKED: begin
                if (frame_done_q) begin
                    state_d = ALIGN;
                    good_d  = 8'd0;
                end
            end
            ALIGN: begin
                if (frame_done_q) begin
                    good_d = good_q + 8'd1;
                    if (good_q + 8'd1 >= LOCK_N) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = UNLOCKED;
                good_d  = 8'd0;
            end
        endcase
        // Errors override any frame credit earned on the same cycle.
        if (h_err_q || v_err_q) begin
            state_d = ALIGN;
            good_d  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q       <= 11'd0;
            vcnt_q       <= 10'd0;
            seen_h_q     <= 1'b0;
            seen_v_q     <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= 10'd0;
            pix_y_q      <= 10'd0;
            pix_rgb_q    <= 12'd0;
            probe_hit_q  <= 1'b0;
            probe_rgb_q  <= 12'd0;
            frame_done_q <= 1'b0;
            h_err_q      <= 1'b0;
            v_err_q      <= 1'b0;
            state_q      <= UNLOCKED;
            good_q       <= 8'd0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            seen_h_q     <= seen_h_d;
            seen_v_q     <= seen_v_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
            probe_hit_q  <= probe_hit_d;
            probe_rgb_q  <= probe_rgb_d;
            frame_done_q <= frame_done_d;
            h_err_q      <= h_err_d;
            v_err_q      <= v_err_d;
            state_q      <= state_d;
            good_q       <= good_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_rgb    = pix_rgb_q;
    assign probe_hit  = probe_hit_q;
    assign probe_rgb  = probe_rgb_q;
    assign frame_done = frame_done_q;
    assign h_err      = h_err_q;
    assign v_err      = v_err_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a shrunken raster (16x9 totals, 8x4 visible).
module tb_vga_sync_decoder;

    localparam int   H_VIS  = 8;
    localparam int   H_FP   = 2;
    localparam int   H_SYNC = 3;
    localparam int   H_BP   = 3;
    localparam int   V_VIS  = 4;
    localparam int   V_FP   = 1;
    localparam int   V_SYNC = 2;
    localparam int   V_BP   = 2;
    localparam int   H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int   V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int   X0     = H_SYNC + H_BP;
    localparam int   Y0     = V_SYNC + V_BP;
    localparam logic POL    = 1'b0;
    localparam int   LOCK_N = 2;

    logic        clk = 1'b0;
    logic        reset, en, hsync, vsync;
    logic [3:0]  R, G, B;
    logic [9:0]  probe_x, probe_y;
    logic        pix_valid, probe_hit, frame_done, locked, h_err, v_err;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb, probe_rgb;

    vga_sync_decoder #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(POL), .LOCK_FRAMES(LOCK_N)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync),
        .R(R), .G(G), .B(B), .probe_x(probe_x), .probe_y(probe_y),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .probe_hit(probe_hit), .probe_rgb(probe_rgb), .frame_done(frame_done),
        .locked(locked), .h_err(h_err), .v_err(v_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
        logic        hit;
        logic        fd;
        logic        herr;
        logic        verr;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   pv_cnt = 0, hit_cnt = 0, herr_cnt = 0, verr_cnt = 0;
    int   g_seed = 0;

    // Stream-side reference state, reset together with the DUT.
    int   g_sc, g_vl, g_lines;
    bit   g_seen_h, g_seen_v;
    logic g_prev_hs, g_prev_vs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] ramp(input int k, input int ln);
        return 12'((k * 37 + ln * 291 + g_seed * 13) & 32'hFFF);
    endfunction

    task automatic strobe(input logic hs, input logic vs, input logic [11:0] rgb);
        exp_t e;
        bit   hst, vst;
        hst = (hs == POL) && (g_prev_hs != POL);
        vst = (vs == POL) && (g_prev_vs != POL);
        g_prev_hs = hs;
        g_prev_vs = vs;
        e = '0;
        if (hst) begin
            e.herr   = g_seen_h && (g_sc + 1 != H_TOT);
            g_seen_h = 1'b1;
            g_sc     = 0;
        end else begin
            if (g_sc < 2047) g_sc++;
            e.herr = (g_sc == 2 * H_TOT);
        end
        if (vst) begin
            e.fd     = 1'b1;
            e.verr   = g_seen_v && (g_lines != V_TOT);
            g_seen_v = 1'b1;
            g_lines  = hst ? 1 : 0;
            g_vl     = 0;
        end else if (hst) begin
            g_lines++;
            g_vl = (g_vl + 1) % 1024;
        end
        if (g_sc >= X0 && g_sc < X0 + H_VIS && g_vl >= Y0 && g_vl < Y0 + V_VIS) begin
            e.valid = 1'b1;
            e.x     = 10'(g_sc - X0);
            e.y     = 10'(g_vl - Y0);
            e.rgb   = rgb;
            e.hit   = (e.x == probe_x) && (e.y == probe_y);
        end
        @(negedge clk);
        en = 1'b1;
        hsync = hs;
        vsync = vs;
        {R, G, B} = rgb;
        sb.push_back(e);
        @(negedge clk);
        en = 1'b0;
        // Garbage between strobes must be ignored.
        hsync = 1'($urandom);
        vsync = 1'($urandom);
        {R, G, B} = 12'($urandom);
    endtask

    task automatic send_line(input int k0, input int len, input int ln);
        for (int k = k0; k < len; k++) begin
            strobe((k < H_SYNC) ? POL : ~POL, (ln < V_SYNC) ? POL : ~POL, ramp(k, ln));
        end
    endtask

    task automatic send_frame(input int nlines, input int bad_ln, input int bad_len);
        g_seed++;
        for (int ln = 0; ln < nlines; ln++) begin
            send_line(0, (ln == bad_ln) ? bad_len : H_TOT, ln);
        end
        $display("frame seed=%0d lines=%0d locked=%0b", g_seed, nlines, locked);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) strobe(~POL, ~POL, 12'h000);
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        g_sc      = 0;
        g_vl      = 0;
        g_lines   = 0;
        g_seen_h  = 1'b0;
        g_seen_v  = 1'b0;
        g_prev_hs = ~POL;
        g_prev_vs = ~POL;
        $display("reset applied at %0t", $time);
    endtask

    // Monitor: one expectation per strobe, zero pulses on other cycles, lock model.
    initial begin : monitor
        logic en_s, rst_s;
        exp_t e;
        int   m_state, m_good;
        logic [11:0] m_probe;
        m_state = 0;
        m_good  = 0;
        m_probe = 12'd0;
        forever begin
            @(posedge clk);
            en_s  = en;
            rst_s = reset;
            @(negedge clk);
            if (rst_s === 1'b1) begin
                chk("reset_out", {pix_valid, pix_x, pix_y, pix_rgb, probe_hit, probe_rgb,
                                  frame_done, locked, h_err, v_err}, 64'd0);
                sb.delete();
                m_state = 0;
                m_good  = 0;
                m_probe = 12'd0;
            end else if (rst_s === 1'b0) begin
                chk("locked", locked, (m_state == 2));
                if (en_s === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("pulses", {pix_valid, probe_hit, frame_done, h_err, v_err},
                                      {e.valid, e.hit, e.fd, e.herr, e.verr});
                        if (e.valid) chk("pixel", {pix_x, pix_y, pix_rgb}, {e.x, e.y, e.rgb});
                        if (e.hit) m_probe = e.rgb;
                        chk("probe_rgb", probe_rgb, m_probe);
                        if (pix_valid) pv_cnt++;
                        if (probe_hit) hit_cnt++;
                        if (h_err) herr_cnt++;
                        if (v_err) verr_cnt++;
                        if (e.herr || e.verr) begin
                            m_state = 1;
                            m_good  = 0;
                        end else if (e.fd) begin
                            if (m_state == 0) begin
                                m_state = 1;
                                m_good  = 0;
                            end else if (m_state == 1) begin
                                m_good++;
                                if (m_good >= LOCK_N) m_state = 2;
                            end
                        end
                    end
                end else begin
                    chk("idle_pulses", {pix_valid, probe_hit, frame_done, h_err, v_err}, 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pv0, hit0, he0, ve0;
        reset = 1'b1;
        en = 1'b0;
        hsync = ~POL;
        vsync = ~POL;
        {R, G, B} = 12'h000;
        probe_x = 10'(H_VIS - 1);
        probe_y = 10'(V_VIS - 1);
        do_reset();

        // Clean stream: lock after the 2nd frame_done following the first.
        send_frame(V_TOT, -1, 0);
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("lock_after_2", locked, 0);
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("lock_after_3", locked, 1);
        pv0 = pv_cnt; hit0 = hit_cnt; ve0 = verr_cnt;
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("pix_per_frame", pv_cnt - pv0, H_VIS * V_VIS);
        chk("hit_per_frame", hit_cnt - hit0, 1);
        chk("probe_value", probe_rgb, ramp(X0 + H_VIS - 1, Y0 + V_VIS - 1));
        chk("no_verr_clean", verr_cnt - ve0, 0);

        // Probe outside the visible area never hits and leaves the capture alone.
        probe_x = 10'(H_VIS);
        probe_y = 10'd0;
        hit0 = hit_cnt;
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("probe_oor_hits", hit_cnt - hit0, 0);
        chk("probe_held", probe_rgb, ramp(X0 + H_VIS - 1, Y0 + V_VIS - 1) - 12'd13);
        probe_x = 10'(H_VIS - 1);
        probe_y = 10'(V_VIS - 1);

        // One short line: single h_err, lock lost, regained after two good frames.
        he0 = herr_cnt;
        send_frame(V_TOT, 5, H_TOT - 1);
        idle_clks(2);
        chk("short_line_herr", herr_cnt - he0, 1);
        chk("unlock_short", locked, 0);
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("relock_1", locked, 0);
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("relock_2", locked, 1);

        // Short frame: v_err at the next vsync start.
        ve0 = verr_cnt;
        send_frame(V_TOT - 1, -1, 0);
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("short_frame_verr", verr_cnt - ve0, 1);

        // Missing hsync: one timeout pulse, no repeats while idle.
        he0 = herr_cnt;
        send_idle(2 * H_TOT + 6);
        idle_clks(2);
        chk("timeout_herr", herr_cnt - he0, 1);
        send_frame(V_TOT, -1, 0);
        send_frame(V_TOT, -1, 0);
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("relock_after_idle", locked, 1);

        // Reset mid-line: outputs cleared, first line afterwards exempt.
        g_seed++;
        for (int ln = 0; ln < 6; ln++) send_line(0, H_TOT, ln);
        send_line(0, 8, 6);
        do_reset();
        he0 = herr_cnt;
        send_line(8, H_TOT, 6);
        send_line(0, H_TOT, 7);
        send_line(0, H_TOT, 8);
        idle_clks(2);
        chk("no_herr_after_reset", herr_cnt - he0, 0);
        chk("unlocked_after_reset", locked, 0);
        send_frame(V_TOT, -1, 0);
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("reset_relock_1", locked, 0);
        send_frame(V_TOT, -1, 0);
        idle_clks(2);
        chk("reset_relock_2", locked, 1);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
